// File: rtl/max_pooling.sv
// Streaming 2x2 stride-2 max pooling over 8-bit raster pixels.
// Frame size (24x24 or 8x8) is captured when the first pixel of a frame is accepted.
module max_pooling (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ivalid,
    input  logic       state,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       ovalid
);

    localparam int unsigned BUF_DEPTH = 12;

    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic       state_q, state_d;
    logic [7:0] pix_q;
    logic [7:0] line_buf_q [BUF_DEPTH];
    logic [7:0] dout_q, dout_d;
    logic       ovalid_q, ovalid_d;

    logic       first_px;
    logic       frame_small;
    logic [4:0] last_idx;
    logic [3:0] buf_idx;
    logic [7:0] hmax;
    logic [7:0] vmax;

    always_comb begin
        first_px    = (col_q == 5'd0) && (row_q == 5'd0);
        // The pixel that opens a frame decides its size, so bypass the latch for it.
        frame_small = first_px ? state : state_q;
        last_idx    = frame_small ? 5'd7 : 5'd23;
        buf_idx     = col_q[4:1];
        hmax        = (din > pix_q) ? din : pix_q;
        vmax        = (line_buf_q[buf_idx] > hmax) ? line_buf_q[buf_idx] : hmax;
    end

    // NOTE: every variable gets its default before any branch, so no latch is inferred.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        state_d  = state_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        if (ivalid) begin
            if (first_px) begin
                state_d = state;
            end
            if (col_q == last_idx) begin
                col_d = 5'd0;
                row_d = (row_q == last_idx) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
            if (col_q[0] && row_q[0]) begin
                ovalid_d = 1'b1;
                dout_d   = vmax;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q    <= 5'd0;
            row_q    <= 5'd0;
            state_q  <= 1'b0;
            pix_q    <= 8'd0;
            dout_q   <= 8'd0;
            ovalid_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            state_q  <= state_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            if (ivalid && !col_q[0]) begin
                pix_q <= din;
            end
        end
    end

    // NOTE: the line buffer is a small register array with a defined reset value,
    // so it is reset explicitly rather than left to power-up contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                line_buf_q[i] <= 8'd0;
            end
        end else if (ivalid && col_q[0] && !row_q[0]) begin
            line_buf_q[buf_idx] <= hmax;
        end
    end

    assign dout   = dout_q;
    assign ovalid = ovalid_q;

endmodule

// File: tb/tb_max_pooling.sv
// Self-checking bench for max_pooling: a per-cycle compare against a window-max
// model of each frame, plus literal result lists for the directed scenarios.
module tb_max_pooling;

    logic       clk;
    logic       rstn;
    logic       ivalid;
    logic       state;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ovalid;

    int n_vec;
    int n_err;

    logic [7:0] img [24][24];
    logic       exp_ovalid;
    logic [7:0] exp_dout;
    logic [7:0] res_q [$];

    max_pooling dut (
        .clk    (clk),
        .rstn   (rstn),
        .ivalid (ivalid),
        .state  (state),
        .din    (din),
        .dout   (dout),
        .ovalid (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: a pooled result is simply the largest of its four source pixels.
    function automatic logic [7:0] window_max(input int r0, input int c0);
        logic [7:0] m;
        m = 8'd0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (img[r0+dr][c0+dc] > m) m = img[r0+dr][c0+dc];
        return m;
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            check("ovalid", {31'd0, ovalid}, {31'd0, exp_ovalid});
            check("dout", {24'd0, dout}, {24'd0, exp_dout});
            if (ovalid === 1'b1) res_q.push_back(dout);
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        ivalid = 1'b0;
        din    = 8'hxx;
        @(posedge clk);
        #1 exp_ovalid = 1'b0;
    endtask

    // Streams a w x w frame from img; optional random gaps, a mid-frame state
    // toggle from pixel toggle_at onwards, and an early stop after max_px pixels.
    task automatic send_frame(input int w, input logic st, input bit gaps,
                              input int toggle_at, input int max_px);
        int idx;
        idx = 0;
        res_q.delete();
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx >= max_px) return;
                if (gaps) begin
                    int g;
                    g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    for (int k = 0; k < g; k++) idle_cycle();
                end
                @(negedge clk);
                ivalid = 1'b1;
                din    = img[r][c];
                state  = (idx >= toggle_at) ? ~st : st;
                @(posedge clk);
                #1;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_ovalid = 1'b1;
                    exp_dout   = window_max(r - 1, c - 1);
                end else begin
                    exp_ovalid = 1'b0;
                end
                idx++;
            end
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic fill_ramp8();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) img[r][c] = 8'(8 * r + c);
    endtask

    task automatic fill_hot(input logic [7:0] bg, input logic [7:0] hot);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) img[r][c] = bg;
        img[0][0] = hot;
        img[0][3] = hot;
        img[3][4] = hot;
        img[7][7] = hot;
    endtask

    task automatic check_ramp8_results(input string tag);
        logic [7:0] lit [16];
        lit = '{8'd9, 8'd11, 8'd13, 8'd15, 8'd25, 8'd27, 8'd29, 8'd31,
                8'd41, 8'd43, 8'd45, 8'd47, 8'd57, 8'd59, 8'd61, 8'd63};
        check({tag, "_count"}, res_q.size(), 16);
        for (int k = 0; k < 16 && k < res_q.size(); k++)
            check($sformatf("%s_res%0d", tag, k), {24'd0, res_q[k]}, {24'd0, lit[k]});
    endtask

    task automatic check_diag24_results(input string tag);
        check({tag, "_count"}, res_q.size(), 144);
        for (int k = 0; k < 144 && k < res_q.size(); k++)
            check($sformatf("%s_res%0d", tag, k), {24'd0, res_q[k]},
                  2 * (k / 12) + 2 * (k % 12) + 2);
    endtask

    task automatic check_hot_results(input string tag, input logic [7:0] bg, input logic [7:0] hot);
        check({tag, "_count"}, res_q.size(), 16);
        for (int k = 0; k < 16 && k < res_q.size(); k++)
            check($sformatf("%s_res%0d", tag, k), {24'd0, res_q[k]},
                  (k == 0 || k == 1 || k == 6 || k == 15) ? {24'd0, hot} : {24'd0, bg});
    endtask

    task automatic fill_diag24();
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++) img[r][c] = 8'(r + c);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rstn       = 1'b0;
        ivalid     = 1'b0;
        state      = 1'b0;
        din        = 8'd0;
        exp_ovalid = 1'b0;
        exp_dout   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", {24'd0, dout}, 0);
        check("reset_ovalid", {31'd0, ovalid}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: 8x8 ramp, continuous.
        fill_ramp8();
        send_frame(8, 1'b1, 1'b0, 1000, 1000);
        check_ramp8_results("s1");

        // 2: 24x24 diagonal.
        fill_diag24();
        send_frame(24, 1'b0, 1'b0, 1000, 1000);
        check_diag24_results("s2");

        // 3: position coverage, then unsigned compare 128 vs 127.
        fill_hot(8'd0, 8'd255);
        send_frame(8, 1'b1, 1'b0, 1000, 1000);
        check_hot_results("s3a", 8'd0, 8'd255);
        fill_hot(8'd127, 8'd128);
        send_frame(8, 1'b1, 1'b0, 1000, 1000);
        check_hot_results("s3b", 8'd127, 8'd128);

        // 4: ramp with random ivalid gaps.
        fill_ramp8();
        send_frame(8, 1'b1, 1'b1, 1000, 1000);
        check_ramp8_results("s4");

        // 5: reset after 20 pixels, then a clean frame.
        send_frame(8, 1'b1, 1'b0, 1000, 20);
        @(negedge clk);
        ivalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midreset_dout", {24'd0, dout}, 0);
        check("midreset_ovalid", {31'd0, ovalid}, 0);
        exp_ovalid = 1'b0;
        exp_dout   = 8'd0;
        @(negedge clk);
        rstn = 1'b1;
        send_frame(8, 1'b1, 1'b0, 1000, 1000);
        check_ramp8_results("s5");

        // 6: back-to-back 8x8 then 24x24 with state toggled mid-frame.
        send_frame(8, 1'b1, 1'b0, 1000, 1000);
        check_ramp8_results("s6a");
        fill_diag24();
        send_frame(24, 1'b0, 1'b1, 100, 1000);
        check_diag24_results("s6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
